// File: rtl/pkt_gen_pkg.sv
// Shared definitions for the synthetic frame generator and its RX-side checker.
package pkt_gen_pkg;

  typedef enum logic [1:0] {StIdle, StSend, StGap, StFin} state_e;

  localparam logic [2:0]  MOD_FULL = 3'd0;
  localparam int unsigned MIN_LEN  = 8;

  // Word k of frame n carries {seed+n, k}; both halves wrap mod 2^32.
  function automatic logic [63:0] pkt_word(input logic [31:0] seed,
                                           input logic [31:0] frame_idx,
                                           input logic [31:0] word_idx);
    pkt_word = {seed + frame_idx, word_idx};
  endfunction

endpackage

// File: rtl/pkt_tx_gen.sv
// Programmable frame generator feeding the xge_mac packet TX interface.
// Emits num_frames frames of frame_len bytes with a checkable payload, honouring pkt_tx_full.
module pkt_tx_gen
  import pkt_gen_pkg::*;
#(
  parameter int unsigned MAX_LEN_W = 14,
  parameter int unsigned GAP_W     = 8
) (
  input  logic                 clk_156m25,
  input  logic                 reset_156m25,
  input  logic                 start,
  input  logic                 stop,
  input  logic [MAX_LEN_W-1:0] frame_len,
  input  logic [15:0]          num_frames,
  input  logic [GAP_W-1:0]     gap_cycles,
  input  logic [31:0]          seed,
  input  logic                 pkt_tx_full,
  output logic                 pkt_tx_val,
  output logic                 pkt_tx_sop,
  output logic                 pkt_tx_eop,
  output logic [2:0]           pkt_tx_mod,
  output logic [63:0]          pkt_tx_data,
  output logic                 busy,
  output logic                 done,
  output logic [31:0]          frames_sent
);

  localparam int unsigned WordW = MAX_LEN_W - 2;

  state_e             state_q, state_d;
  logic               stop_q, stop_d;
  logic [WordW-1:0]   words_q, words_d;
  logic [2:0]         len_mod_q, len_mod_d;
  logic [15:0]        num_q, num_d;
  logic [GAP_W-1:0]   gap_q, gap_d;
  logic [GAP_W-1:0]   gap_cnt_q, gap_cnt_d;
  logic [31:0]        seed_q, seed_d;
  logic [31:0]        frame_idx_q, frame_idx_d;
  logic [WordW-1:0]   word_idx_q, word_idx_d;
  logic [31:0]        frames_sent_q, frames_sent_d;

  logic               val_q, val_d;
  logic               sop_q, sop_d;
  logic               eop_q, eop_d;
  logic [2:0]         mod_q, mod_d;
  logic [63:0]        data_q, data_d;
  logic               busy_q, busy_d;
  logic               done_q, done_d;

  logic               issue;
  logic               last_word;
  logic               start_ok;
  logic [MAX_LEN_W-1:0] len_clamp;
  logic [MAX_LEN_W:0]   len_sum;

  assign len_clamp = (frame_len < MAX_LEN_W'(MIN_LEN)) ? MAX_LEN_W'(MIN_LEN) : frame_len;
  assign len_sum   = {1'b0, len_clamp} + (MAX_LEN_W + 1)'(7);
  assign last_word = (word_idx_q == (words_q - WordW'(1)));
  // busy stays high through the done cycle, so a start there is still ignored.
  assign start_ok  = start && (state_q == StIdle) && !busy_q;

  always_ff @(posedge clk_156m25) begin
    if (reset_156m25) begin
      state_q       <= StIdle;
      stop_q        <= 1'b0;
      words_q       <= '0;
      len_mod_q     <= '0;
      num_q         <= '0;
      gap_q         <= '0;
      gap_cnt_q     <= '0;
      seed_q        <= '0;
      frame_idx_q   <= '0;
      word_idx_q    <= '0;
      frames_sent_q <= '0;
      val_q         <= 1'b0;
      sop_q         <= 1'b0;
      eop_q         <= 1'b0;
      mod_q         <= '0;
      data_q        <= '0;
      busy_q        <= 1'b0;
      done_q        <= 1'b0;
    end else begin
      state_q       <= state_d;
      stop_q        <= stop_d;
      words_q       <= words_d;
      len_mod_q     <= len_mod_d;
      num_q         <= num_d;
      gap_q         <= gap_d;
      gap_cnt_q     <= gap_cnt_d;
      seed_q        <= seed_d;
      frame_idx_q   <= frame_idx_d;
      word_idx_q    <= word_idx_d;
      frames_sent_q <= frames_sent_d;
      val_q         <= val_d;
      sop_q         <= sop_d;
      eop_q         <= eop_d;
      mod_q         <= mod_d;
      data_q        <= data_d;
      busy_q        <= busy_d;
      done_q        <= done_d;
    end
  end

  always_comb begin
    state_d       = state_q;
    stop_d        = stop_q;
    words_d       = words_q;
    len_mod_d     = len_mod_q;
    num_d         = num_q;
    gap_d         = gap_q;
    gap_cnt_d     = gap_cnt_q;
    seed_d        = seed_q;
    frame_idx_d   = frame_idx_q;
    word_idx_d    = word_idx_q;
    frames_sent_d = frames_sent_q;
    issue         = 1'b0;
    unique case (state_q)
      StIdle: begin
        if (start_ok) begin
          state_d       = StSend;
          words_d       = len_sum[MAX_LEN_W:3];
          len_mod_d     = len_clamp[2:0];
          num_d         = num_frames;
          gap_d         = gap_cycles;
          seed_d        = seed;
          frame_idx_d   = '0;
          word_idx_d    = '0;
          frames_sent_d = '0;
          stop_d        = stop;
        end
      end
      StSend: begin
        stop_d = stop_q | stop;
        if (!pkt_tx_full) begin
          issue = 1'b1;
          if (last_word) begin
            frames_sent_d = frames_sent_q + 32'd1;
            word_idx_d    = '0;
            if (((num_q != 16'd0) && (frames_sent_d == 32'(num_q))) || stop_q || stop) begin
              state_d = StFin;
            end else if (gap_q != '0) begin
              state_d   = StGap;
              gap_cnt_d = '0;
            end else begin
              frame_idx_d = frame_idx_q + 32'd1;
            end
          end else begin
            word_idx_d = word_idx_q + WordW'(1);
          end
        end
      end
      StGap: begin
        stop_d = stop_q | stop;
        if (stop_q || stop) begin
          state_d = StFin;
        end else if (gap_cnt_q == (gap_q - GAP_W'(1))) begin
          state_d     = StSend;
          frame_idx_d = frame_idx_q + 32'd1;
        end else begin
          gap_cnt_d = gap_cnt_q + GAP_W'(1);
        end
      end
      StFin: begin
        state_d = StIdle;
        stop_d  = 1'b0;
      end
      default: state_d = StIdle;
    endcase
  end

  always_comb begin
    val_d  = issue;
    sop_d  = issue && (word_idx_q == '0);
    eop_d  = issue && last_word;
    mod_d  = (issue && last_word) ? len_mod_q : MOD_FULL;
    data_d = issue ? pkt_word(seed_q, frame_idx_q, 32'(word_idx_q)) : 64'd0;
    done_d = (state_q == StFin);
    busy_d = (state_d != StIdle) || (state_q == StFin);
  end

  assign pkt_tx_val  = val_q;
  assign pkt_tx_sop  = sop_q;
  assign pkt_tx_eop  = eop_q;
  assign pkt_tx_mod  = mod_q;
  assign pkt_tx_data = data_q;
  assign busy        = busy_q;
  assign done        = done_q;
  assign frames_sent = frames_sent_q;

endmodule

// File: tb/tb_pkt_tx_gen.sv
// Scoreboard bench for pkt_tx_gen: expected words queued at start, observed words captured
// by a monitor, each scenario task compares its own results.
module tb_pkt_tx_gen;

  logic        clk_156m25 = 1'b0;
  logic        reset_156m25;
  logic        start;
  logic        stop;
  logic [13:0] frame_len;
  logic [15:0] num_frames;
  logic [7:0]  gap_cycles;
  logic [31:0] seed;
  logic        pkt_tx_full;
  logic        pkt_tx_val;
  logic        pkt_tx_sop;
  logic        pkt_tx_eop;
  logic [2:0]  pkt_tx_mod;
  logic [63:0] pkt_tx_data;
  logic        busy;
  logic        done;
  logic [31:0] frames_sent;

  typedef struct packed {
    logic        sop;
    logic        eop;
    logic [2:0]  mod;
    logic [63:0] data;
  } word_t;

  word_t exp_q[$];
  word_t obs_q[$];
  int    obs_cyc[$];
  int    done_cyc[$];
  int    cyc = 0;
  int    start_cyc = 0;
  int    n_cmp = 0;
  int    n_err = 0;

  pkt_tx_gen #(
    .MAX_LEN_W(14),
    .GAP_W    (8)
  ) dut (
    .clk_156m25  (clk_156m25),
    .reset_156m25(reset_156m25),
    .start       (start),
    .stop        (stop),
    .frame_len   (frame_len),
    .num_frames  (num_frames),
    .gap_cycles  (gap_cycles),
    .seed        (seed),
    .pkt_tx_full (pkt_tx_full),
    .pkt_tx_val  (pkt_tx_val),
    .pkt_tx_sop  (pkt_tx_sop),
    .pkt_tx_eop  (pkt_tx_eop),
    .pkt_tx_mod  (pkt_tx_mod),
    .pkt_tx_data (pkt_tx_data),
    .busy        (busy),
    .done        (done),
    .frames_sent (frames_sent)
  );

  always #5 clk_156m25 = ~clk_156m25;

  always @(negedge clk_156m25) begin
    cyc = cyc + 1;
    if (pkt_tx_val) begin
      obs_q.push_back(word_t'({pkt_tx_sop, pkt_tx_eop, pkt_tx_mod, pkt_tx_data}));
      obs_cyc.push_back(cyc);
    end
    if (done) done_cyc.push_back(cyc);
  end

  task automatic clear_sb();
    exp_q.delete();
    obs_q.delete();
    obs_cyc.delete();
    done_cyc.delete();
  endtask

  // Reference model: frame n, word k = {seed+n, k}; mod = len%8 on the last word only.
  task automatic push_frames(input int len, input int nf, input logic [31:0] sd);
    int    l;
    int    w;
    word_t e;
    l = (len < 8) ? 8 : len;
    w = (l + 7) / 8;
    for (int n = 0; n < nf; n++) begin
      for (int k = 0; k < w; k++) begin
        e.sop  = (k == 0);
        e.eop  = (k == w - 1);
        e.mod  = (k == w - 1) ? 3'(l % 8) : 3'd0;
        e.data = {sd + 32'(n), 32'(k)};
        exp_q.push_back(e);
      end
    end
  endtask

  task automatic kick(input int len, input int nf, input int gap, input logic [31:0] sd,
                      input logic with_stop);
    @(posedge clk_156m25);
    #1;
    frame_len  = 14'(len);
    num_frames = 16'(nf);
    gap_cycles = 8'(gap);
    seed       = sd;
    start      = 1'b1;
    stop       = with_stop;
    start_cyc  = cyc;
    @(posedge clk_156m25);
    #1;
    start = 1'b0;
    stop  = 1'b0;
  endtask

  task automatic wait_done(input int budget, output bit timed_out);
    timed_out = 1'b1;
    for (int i = 0; i < budget; i++) begin
      @(negedge clk_156m25);
      if (done) begin
        timed_out = 1'b0;
        break;
      end
    end
    @(negedge clk_156m25);
    #1;
  endtask

  task automatic wait_word(input logic [31:0] upper, input logic [31:0] k, output bit found);
    found = 1'b0;
    for (int i = 0; i < 300; i++) begin
      @(negedge clk_156m25);
      if (pkt_tx_val && pkt_tx_data[63:32] == upper && pkt_tx_data[31:0] == k) begin
        found = 1'b1;
        break;
      end
    end
  endtask

  task automatic test_reset();
    reset_156m25 = 1'b1;
    start = 1'b0; stop = 1'b0; pkt_tx_full = 1'b0;
    frame_len = '0; num_frames = '0; gap_cycles = '0; seed = '0;
    repeat (3) @(posedge clk_156m25);
    #1;
    n_cmp++;
    if ({pkt_tx_val, pkt_tx_sop, pkt_tx_eop, pkt_tx_mod, pkt_tx_data, busy, done, frames_sent}
        !== '0) begin
      n_err++;
      $display("FAIL reset_outputs: got val=%b busy=%b done=%b sent=%0d data=%h, want all 0",
               pkt_tx_val, busy, done, frames_sent, pkt_tx_data);
    end
    reset_156m25 = 1'b0;
  endtask

  task automatic test_single();
    bit    to;
    word_t e, o;
    clear_sb();
    push_frames(24, 1, 32'h100);
    kick(24, 1, 0, 32'h100, 1'b0);
    n_cmp++;
    if (busy !== 1'b1) begin
      n_err++; $display("FAIL single_busy: got %b want 1", busy);
    end
    wait_done(200, to);
    n_cmp++;
    if (to) begin n_err++; $display("FAIL single_done_timeout: got none want done"); end
    n_cmp++;
    if (obs_q.size() != 3) begin
      n_err++; $display("FAIL single_count: got %0d want 3", obs_q.size());
    end else begin
      n_cmp++;
      if (obs_cyc[0] - start_cyc < 2) begin
        n_err++; $display("FAIL single_latency: got %0d want >=2", obs_cyc[0] - start_cyc);
      end
      n_cmp++;
      if (done_cyc.size() != 1 || done_cyc[0] != obs_cyc[2] + 1) begin
        n_err++; $display("FAIL single_done_timing: got %0d pulses want 1 after eop",
                          done_cyc.size());
      end
    end
    while (exp_q.size() > 0 && obs_q.size() > 0) begin
      e = exp_q.pop_front();
      o = obs_q.pop_front();
      n_cmp++;
      if (o !== e) begin n_err++; $display("FAIL single_word: got %h want %h", o, e); end
    end
    n_cmp++;
    if (frames_sent !== 32'd1 || busy !== 1'b0) begin
      n_err++; $display("FAIL single_final: got sent=%0d busy=%b want 1/0", frames_sent, busy);
    end
  endtask

  task automatic test_gap();
    bit    to;
    word_t e, o;
    clear_sb();
    push_frames(17, 3, 32'h100);
    kick(17, 3, 4, 32'h100, 1'b0);
    wait_done(300, to);
    n_cmp++;
    if (to) begin n_err++; $display("FAIL gap_done_timeout: got none want done"); end
    n_cmp++;
    if (obs_q.size() != 9) begin
      n_err++; $display("FAIL gap_count: got %0d want 9", obs_q.size());
    end else begin
      for (int f = 0; f < 2; f++) begin
        n_cmp++;
        if (obs_cyc[3*f+3] - obs_cyc[3*f+2] != 5) begin
          n_err++; $display("FAIL gap_idle%0d: got %0d idle want 4", f,
                            obs_cyc[3*f+3] - obs_cyc[3*f+2] - 1);
        end
      end
    end
    while (exp_q.size() > 0 && obs_q.size() > 0) begin
      e = exp_q.pop_front();
      o = obs_q.pop_front();
      n_cmp++;
      if (o !== e) begin n_err++; $display("FAIL gap_word: got %h want %h", o, e); end
    end
    n_cmp++;
    if (frames_sent !== 32'd3) begin
      n_err++; $display("FAIL gap_sent: got %0d want 3", frames_sent);
    end
  endtask

  task automatic test_back_to_back();
    bit    to;
    word_t e, o;
    int    lens[2] = '{8, 3};
    foreach (lens[j]) begin
      clear_sb();
      push_frames(lens[j], 2, 32'hA0);
      kick(lens[j], 2, 0, 32'hA0, 1'b0);
      wait_done(100, to);
      n_cmp++;
      if (to) begin n_err++; $display("FAIL b2b_done_timeout len=%0d: got none", lens[j]); end
      n_cmp++;
      if (obs_q.size() != 2 || obs_cyc[1] - obs_cyc[0] != 1) begin
        n_err++; $display("FAIL b2b_spacing len=%0d: got %0d words want 2 adjacent",
                          lens[j], obs_q.size());
      end
      while (exp_q.size() > 0 && obs_q.size() > 0) begin
        e = exp_q.pop_front();
        o = obs_q.pop_front();
        n_cmp++;
        if (o !== e) begin n_err++; $display("FAIL b2b_word: got %h want %h", o, e); end
      end
    end
  endtask

  task automatic test_backpressure();
    bit    to, found;
    word_t e, o;
    clear_sb();
    push_frames(64, 1, 32'h200);
    kick(64, 1, 0, 32'h200, 1'b0);
    wait_word(32'h200, 32'd2, found);
    pkt_tx_full = 1'b1;
    repeat (5) @(posedge clk_156m25);
    #1;
    pkt_tx_full = 1'b0;
    n_cmp++;
    if (!found) begin n_err++; $display("FAIL bp_word2: got none want word 2"); end
    wait_done(200, to);
    n_cmp++;
    if (to) begin n_err++; $display("FAIL bp_done_timeout: got none want done"); end
    n_cmp++;
    if (obs_q.size() != 8) begin
      n_err++; $display("FAIL bp_count: got %0d want 8", obs_q.size());
    end else begin
      n_cmp++;
      if (obs_cyc[3] - obs_cyc[2] != 6) begin
        n_err++; $display("FAIL bp_stall: got %0d idle want 5", obs_cyc[3] - obs_cyc[2] - 1);
      end
    end
    while (exp_q.size() > 0 && obs_q.size() > 0) begin
      e = exp_q.pop_front();
      o = obs_q.pop_front();
      n_cmp++;
      if (o !== e) begin n_err++; $display("FAIL bp_word: got %h want %h", o, e); end
    end
  endtask

  task automatic test_stop();
    bit    to, found;
    word_t e, o;
    logic [31:0] sd;
    sd = 32'hFFFF_FFFE;
    clear_sb();
    push_frames(20, 4, sd);
    kick(20, 0, 2, sd, 1'b0);
    repeat (4) @(posedge clk_156m25);
    #1;
    frame_len = 14'd8; num_frames = 16'd1; seed = 32'h0; start = 1'b1;
    @(posedge clk_156m25);
    #1;
    start = 1'b0;
    wait_word(sd + 32'd3, 32'd1, found);
    stop = 1'b1;
    @(posedge clk_156m25);
    #1;
    stop = 1'b0;
    n_cmp++;
    if (!found) begin n_err++; $display("FAIL stop_frame3: got none want frame 3 word 1"); end
    wait_done(100, to);
    n_cmp++;
    if (to) begin n_err++; $display("FAIL stop_done_timeout: got none want done"); end
    n_cmp++;
    if (obs_q.size() != exp_q.size() || done_cyc.size() != 1) begin
      n_err++; $display("FAIL stop_count: got %0d words/%0d done want %0d/1",
                        obs_q.size(), done_cyc.size(), exp_q.size());
    end
    while (exp_q.size() > 0 && obs_q.size() > 0) begin
      e = exp_q.pop_front();
      o = obs_q.pop_front();
      n_cmp++;
      if (o !== e) begin n_err++; $display("FAIL stop_word: got %h want %h", o, e); end
    end
    n_cmp++;
    if (frames_sent !== 32'd4) begin
      n_err++; $display("FAIL stop_sent: got %0d want 4", frames_sent);
    end
  endtask

  task automatic test_stop_with_start();
    bit to;
    clear_sb();
    push_frames(16, 1, 32'h300);
    kick(16, 5, 0, 32'h300, 1'b1);
    wait_done(100, to);
    n_cmp++;
    if (to || obs_q.size() != 2 || frames_sent !== 32'd1) begin
      n_err++; $display("FAIL stop_at_start: got %0d words sent=%0d want 2 words sent=1",
                        obs_q.size(), frames_sent);
    end
  endtask

  task automatic test_reset_mid();
    bit    to, found;
    word_t e, o;
    clear_sb();
    kick(64, 1, 0, 32'h55, 1'b0);
    wait_word(32'h55, 32'd3, found);
    reset_156m25 = 1'b1;
    @(posedge clk_156m25);
    #1;
    n_cmp++;
    if (!found || {pkt_tx_val, pkt_tx_sop, pkt_tx_eop, pkt_tx_mod, pkt_tx_data, busy, done,
                   frames_sent} !== '0) begin
      n_err++; $display("FAIL midreset_outputs: got val=%b busy=%b sent=%0d want all 0",
                        pkt_tx_val, busy, frames_sent);
    end
    reset_156m25 = 1'b0;
    repeat (20) @(negedge clk_156m25);
    n_cmp++;
    if (done_cyc.size() != 0) begin
      n_err++; $display("FAIL midreset_done: got %0d pulses want 0", done_cyc.size());
    end
    clear_sb();
    push_frames(16, 1, 32'h77);
    kick(16, 1, 0, 32'h77, 1'b0);
    n_cmp++;
    if (busy !== 1'b1 || frames_sent !== 32'd0) begin
      n_err++; $display("FAIL midreset_restart: got busy=%b sent=%0d want 1/0", busy,
                        frames_sent);
    end
    wait_done(100, to);
    n_cmp++;
    if (to || obs_q.size() != 2) begin
      n_err++; $display("FAIL midreset_count: got %0d words want 2", obs_q.size());
    end
    while (exp_q.size() > 0 && obs_q.size() > 0) begin
      e = exp_q.pop_front();
      o = obs_q.pop_front();
      n_cmp++;
      if (o !== e) begin n_err++; $display("FAIL midreset_word: got %h want %h", o, e); end
    end
    n_cmp++;
    if (frames_sent !== 32'd1) begin
      n_err++; $display("FAIL midreset_sent: got %0d want 1", frames_sent);
    end
  endtask

  initial begin
    test_reset();
    test_single();
    test_gap();
    test_back_to_back();
    test_backpressure();
    test_stop();
    test_stop_with_start();
    test_reset_mid();
    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
    $finish;
  end

  initial begin
    #500000;
    $display("FAIL watchdog: simulation did not finish, want finish before 500000");
    $fatal(1, "watchdog");
  end

endmodule

// File: doc/pkt_tx_gen.md
Name: pkt_tx_gen

Overview:
- Synthetic frame generator sitting directly upstream of xge_mac's packet TX interface (pkt_tx_val/sop/eop/mod/data, pkt_tx_full), in the clk_156m25 domain.
- Produces a programmable number of frames of programmable byte length with a deterministic, checkable payload, honouring TX FIFO back-pressure.
- Intended driver for MAC loopback bring-up and regression; the RX side checks the payload pattern.

Parameters:
- MAX_LEN_W, 14, width of frame_len in bytes (max frame 16383 bytes).
- GAP_W, 8, width of gap_cycles.

Ports:
- clk_156m25  in  1  core clock.
- reset_156m25  in  1  synchronous, active-high reset.
- start  in  1  one-cycle pulse; samples config and begins a run; ignored while busy=1.
- stop  in  1  level/pulse; finish the current frame, then end the run.
- frame_len  in  MAX_LEN_W  frame length in bytes; values <8 are treated as 8.
- num_frames  in  16  frames per run; 0 = continuous until stop.
- gap_cycles  in  GAP_W  idle cycles between frames (val=0); 0 = back-to-back.
- seed  in  32  payload sequence base.
- pkt_tx_full  in  1  MAC TX FIFO full / back-pressure.
- pkt_tx_val  out  1  word valid.
- pkt_tx_sop  out  1  first word of frame.
- pkt_tx_eop  out  1  last word of frame.
- pkt_tx_mod  out  3  valid bytes in eop word mod 8 (0 = all 8).
- pkt_tx_data  out  64  payload word.
- busy  out  1  run in progress.
- done  out  1  one-cycle pulse at end of run.
- frames_sent  out  32  frames issued in current/last run.

Behaviour:
- Single clock clk_156m25; reset_156m25 is synchronous and active-high.
- All outputs are registered. On reset: all outputs 0, state IDLE, counters 0.
- Reset mid-frame: outputs are 0 at the next edge. No eop is sent and the frame is abandoned.
- start sampling (while IDLE): latch len=max(frame_len,8), num_frames, gap_cycles and seed.
  - Clear frames_sent; set busy=1 next cycle.
- Word count: words = ceil(len/8) = (len+7)>>3. mod = len[2:0].
- Payload: word k (k=0..words-1) of frame n (n=0..) is {seed+n [31:0], k [31:0]}. Arithmetic wraps mod 2^32.
- Back-pressure: a word is issued (val=1 at edge t+1) only if pkt_tx_full=0 at edge t.
  - Otherwise val=0 that cycle and the word index holds.
  - Stalls may occur mid-frame; sop/eop/mod/data are qualified only by val.
- States:
  - IDLE: busy=0. start -> SEND.
  - SEND: issue words per back-pressure. sop=1 with k=0; eop=1 and mod driven with k=words-1, otherwise mod=0.
    - 1-word frame (len 8): sop=eop=1, mod=0.
    - After eop: frames_sent++.
    - If (num_frames!=0 and frames_sent==num_frames) or a stop is latched -> FIN.
    - Else if gap_cycles!=0 -> GAP, else stay in SEND with n++ (back-to-back: next sop can follow eop on the very next cycle).
  - GAP: val=0 for exactly gap_cycles cycles, then SEND with n++.
    - stop seen in GAP -> FIN immediately.
  - FIN: done=1 for one cycle, busy=0 next cycle -> IDLE.
- stop is latched sticky until FIN. stop in IDLE is ignored.
- stop on the same cycle as start: the run sends exactly one frame.
- Simultaneous stop and eop: the current frame completes, then FIN.
- start during busy is ignored; it does not restart or reload config.
- frames_sent wraps at 2^32. It holds its value after done until the next start.
- Latency: first sop with val=1 no earlier than 2 cycles after the start pulse, given pkt_tx_full=0.

Decomposition:
- Shared package pkt_gen_pkg holds:
  - state enum (IDLE, SEND, GAP, FIN);
  - MOD_FULL=3'd0;
  - MIN_LEN=8;
  - the payload word formula as a function, reused by the RX-side checker.
- No sub-module; single module.

Test Plan:
- len=24, num=1, gap=0, seed=0x100, full=0 -> 3 words {0x100,0},{0x100,1},{0x100,2}; sop on w0, eop+mod=0 on w2; done 1 cycle after eop; frames_sent=1.
- len=17, num=3, gap=4 -> 3 words/frame, eop mod=1; exactly 4 val=0 cycles between frames; upper data 0x100,0x101,0x102; frames_sent=3.
- len=8 and len=3 (clamped), num=2, gap=0 -> sop=eop=1 every word, mod=0, back-to-back on consecutive cycles.
- len=64, num=1; pkt_tx_full high for 5 cycles after word 2 -> val=0 for those cycles; word 3 follows with k=3; no word lost or duplicated; 8 words total.
- num=0, gap=2, assert stop mid-frame 3 -> frame 3 completes with eop, then done; frames_sent=4 (frames 0..3); start while busy earlier has no effect.
- reset_156m25 pulsed mid-frame -> outputs 0 next edge, busy=0, no done; a new start then works normally from k=0 with frames_sent=0.
